// File: rtl/pipe_reg_chain.sv
// ---------------------------------------------------------------------------
// pipe_reg_chain
//   Parametrised pipeline delay line of DEPTH register stages, each holding a
//   valid bit and WIDTH bits of data. Stage 0 is the youngest and stage
//   DEPTH-1 is the oldest, which drives the outputs. The chain supports a
//   global stall (en=0) and a per-stage squash (flush_mask) for hazard and
//   branch handling. It also reports a registered count of the valid stages.
//
// Parameters
//   WIDTH      data bits per stage (>=1)
//   DEPTH      number of stages (>=1)
//   RESET_VAL  data value of an empty stage (after reset, squash or bubble)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   en          1 = shift the chain by one stage, 0 = hold every stage
//   in_valid    stage-0 input is real
//   in_data     stage-0 input data
//   flush_mask  bit i squashes the destination of stage i on this edge
//   out_valid   valid bit of the oldest stage
//   out_data    data of the oldest stage
//   occupancy   number of valid stages (0..DEPTH)
// ---------------------------------------------------------------------------
module pipe_reg_chain #(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       DEPTH     = 3,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [DEPTH-1:0]            flush_mask,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0]             valid_d;
  logic [DEPTH-1:0]             shift_valid;
  logic [DEPTH-1:0][WIDTH-1:0]  data_q;
  logic [DEPTH-1:0][WIDTH-1:0]  data_d;
  logic [DEPTH-1:0][WIDTH-1:0]  shift_data;
  logic [OCC_W-1:0]             occ_q;
  logic [OCC_W-1:0]             occ_d;

  // Contents each stage would take if the chain advances. An invalid input
  // enters as a bubble so that empty stages always carry RESET_VAL.
  always_comb begin
    shift_valid    = '0;
    shift_data     = '0;
    shift_valid[0] = in_valid;
    shift_data[0]  = in_valid ? in_data : RESET_VAL;
    for (int i = 1; i < DEPTH; i++) begin
      shift_valid[i] = valid_q[i-1];
      shift_data[i]  = data_q[i-1];
    end
  end

  // Squash is applied on top of the advance/hold choice, so a masked stage
  // becomes a bubble whatever en says.
  always_comb begin
    valid_d = en ? shift_valid : valid_q;
    data_d  = en ? shift_data  : data_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush_mask[i]) begin
        valid_d[i] = 1'b0;
        data_d[i]  = RESET_VAL;
      end
    end
  end

  // Count is taken from the next-state valids so the registered value lines
  // up with the stage registers written on the same edge.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OCC_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= {DEPTH{RESET_VAL}};
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// ---------------------------------------------------------------------------
// tb_pipe_reg_chain
//   Self-checking bench for pipe_reg_chain. A WIDTH=8/DEPTH=3/RESET_VAL=0
//   instance runs directed scenarios and randomized traffic against an
//   array-based reference model; a WIDTH=4/DEPTH=1/RESET_VAL=5 instance
//   covers the single-register build.
// ---------------------------------------------------------------------------
module tb_pipe_reg_chain;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int W1 = 4;
  localparam logic [W1-1:0] RV1 = 4'h5;

  logic          clk;
  logic          rst;
  logic          en;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic [D-1:0]  flush_mask;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;

  logic          en1;
  logic          in_valid1;
  logic [W1-1:0] in_data1;
  logic [0:0]    flush_mask1;
  logic          out_valid1;
  logic [W1-1:0] out_data1;
  logic [0:0]    occupancy1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one entry per stage, index D-1 is the oldest.
  logic         mv [D];
  logic [W-1:0] md [D];

  pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .flush_mask(flush_mask), .out_valid(out_valid), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_reg_chain #(.WIDTH(W1), .DEPTH(1), .RESET_VAL(RV1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .in_valid(in_valid1), .in_data(in_data1),
    .flush_mask(flush_mask1), .out_valid(out_valid1), .out_data(out_data1),
    .occupancy(occupancy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
  endtask

  function automatic logic [1:0] model_occ();
    int c = 0;
    for (int i = 0; i < D; i++) c += int'(mv[i]);
    return 2'(c);
  endfunction

  // Drive one cycle on the main instance and advance the model by the
  // chain's rules: shift on en, then squash masked stages.
  task automatic drive_cycle(input logic e, input logic v, input logic [W-1:0] d,
                             input logic [D-1:0] m);
    en = e; in_valid = v; in_data = d; flush_mask = m;
    @(posedge clk);
    if (e) begin
      for (int i = D - 1; i > 0; i--) begin
        mv[i] = mv[i-1];
        md[i] = md[i-1];
      end
      mv[0] = v;
      md[0] = v ? d : '0;
    end
    for (int i = 0; i < D; i++) begin
      if (m[i]) begin
        mv[i] = 1'b0;
        md[i] = '0;
      end
    end
    #1;
  endtask

  task automatic fill3(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    drive_cycle(1'b0, 1'b0, '0, '1);
    drive_cycle(1'b1, 1'b1, a, '0);
    drive_cycle(1'b1, 1'b1, b, '0);
    drive_cycle(1'b1, 1'b1, c, '0);
  endtask

  task automatic test_reset();
    en1 = 1'b1; in_valid1 = 1'b1; in_data1 = 4'hA; flush_mask1 = 1'b0;
    drive_cycle(1'b1, 1'b1, 8'hAA, '0);
    drive_cycle(1'b1, 1'b1, 8'hAA, '0);
    drive_cycle(1'b1, 1'b1, 8'hAA, '0);
    n_cmp++;
    if ({out_valid, out_data, occupancy} !== {1'b1, 8'hAA, 2'd3}) begin
      n_err++;
      $display("FAIL reset_prefill: got v=%0b d=%0h occ=%0d want v=1 d=aa occ=3",
               out_valid, out_data, occupancy);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, out_data, occupancy} !== {1'b0, 8'h00, 2'd0}) begin
      n_err++;
      $display("FAIL reset_async: got v=%0b d=%0h occ=%0d want v=0 d=0 occ=0",
               out_valid, out_data, occupancy);
    end
    n_cmp++;
    if ({out_valid1, out_data1, occupancy1} !== {1'b0, RV1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_async_d1: got v=%0b d=%0h occ=%0d want v=0 d=%0h occ=0",
               out_valid1, out_data1, occupancy1, RV1);
    end
    en1 = 1'b0; in_valid1 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_streaming();
    logic [W-1:0] ins   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic         exp_v [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] exp_d [4] = '{8'h00, 8'h00, 8'h11, 8'h22};
    logic [1:0]   exp_o [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b1, 1'b1, ins[k], '0);
      n_cmp++;
      if ({out_valid, out_data, occupancy} !== {exp_v[k], exp_d[k], exp_o[k]}) begin
        n_err++;
        $display("FAIL stream[%0d]: got v=%0b d=%0h occ=%0d want v=%0b d=%0h occ=%0d",
                 k, out_valid, out_data, occupancy, exp_v[k], exp_d[k], exp_o[k]);
      end
    end
  endtask

  task automatic test_stall();
    logic         exp_v [3] = '{1'b1, 1'b1, 1'b0};
    logic [W-1:0] exp_d [3] = '{8'h22, 8'h33, 8'h00};
    logic [1:0]   exp_o [3] = '{2'd2, 2'd1, 2'd0};
    fill3(8'h11, 8'h22, 8'h33);
    for (int k = 0; k < 2; k++) begin
      drive_cycle(1'b0, 1'b1, 8'h55, '0);
      n_cmp++;
      if ({out_valid, out_data, occupancy} !== {1'b1, 8'h11, 2'd3}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got v=%0b d=%0h occ=%0d want v=1 d=11 occ=3",
                 k, out_valid, out_data, occupancy);
      end
    end
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b1, 1'b0, 8'h55, '0);
      n_cmp++;
      if ({out_valid, out_data, occupancy} !== {exp_v[k], exp_d[k], exp_o[k]}) begin
        n_err++;
        $display("FAIL stall_resume[%0d]: got v=%0b d=%0h occ=%0d want v=%0b d=%0h occ=%0d",
                 k, out_valid, out_data, occupancy, exp_v[k], exp_d[k], exp_o[k]);
      end
    end
  endtask

  task automatic test_squash_stall();
    fill3(8'h11, 8'h22, 8'h33);
    drive_cycle(1'b0, 1'b1, 8'h66, 3'b011);
    n_cmp++;
    if ({out_valid, out_data, occupancy} !== {1'b1, 8'h11, 2'd1}) begin
      n_err++;
      $display("FAIL squash_stall: got v=%0b d=%0h occ=%0d want v=1 d=11 occ=1",
               out_valid, out_data, occupancy);
    end
    drive_cycle(1'b1, 1'b0, '0, '0);
    n_cmp++;
    if ({out_valid, out_data, occupancy} !== {1'b0, 8'h00, 2'd0}) begin
      n_err++;
      $display("FAIL squash_stall_drain: got v=%0b d=%0h occ=%0d want v=0 d=0 occ=0",
               out_valid, out_data, occupancy);
    end
  endtask

  task automatic test_squash_advance();
    logic         exp_v [3] = '{1'b1, 1'b1, 1'b0};
    logic [W-1:0] exp_d [3] = '{8'h22, 8'h33, 8'h00};
    logic [1:0]   exp_o [3] = '{2'd2, 2'd1, 2'd0};
    fill3(8'h11, 8'h22, 8'h33);
    for (int k = 0; k < 3; k++) begin
      if (k == 0) drive_cycle(1'b1, 1'b1, 8'h44, 3'b001);
      else        drive_cycle(1'b1, 1'b0, 8'h00, 3'b000);
      n_cmp++;
      if ({out_valid, out_data, occupancy} !== {exp_v[k], exp_d[k], exp_o[k]}) begin
        n_err++;
        $display("FAIL squash_adv[%0d]: got v=%0b d=%0h occ=%0d want v=%0b d=%0h occ=%0d",
                 k, out_valid, out_data, occupancy, exp_v[k], exp_d[k], exp_o[k]);
      end
    end
  endtask

  task automatic test_full_flush();
    fill3(8'hA1, 8'hB2, 8'hC3);
    drive_cycle(1'b1, 1'b1, 8'hD4, 3'b111);
    n_cmp++;
    if ({out_valid, out_data, occupancy} !== {1'b0, 8'h00, 2'd0}) begin
      n_err++;
      $display("FAIL full_flush: got v=%0b d=%0h occ=%0d want v=0 d=0 occ=0",
               out_valid, out_data, occupancy);
    end
  endtask

  task automatic test_random();
    logic [D-1:0] m;
    for (int k = 0; k < 300; k++) begin
      m = '0;
      for (int b = 0; b < D; b++) m[b] = ($urandom_range(0, 7) == 0);
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  W'($urandom()), m);
      n_cmp++;
      if ({out_valid, out_data, occupancy} !== {mv[D-1], md[D-1], model_occ()}) begin
        n_err++;
        $display("FAIL random[%0d]: got v=%0b d=%0h occ=%0d want v=%0b d=%0h occ=%0d",
                 k, out_valid, out_data, occupancy, mv[D-1], md[D-1], model_occ());
      end
    end
  endtask

  task automatic test_depth1();
    logic          v1 = 1'b0;
    logic [W1-1:0] d1 = RV1;
    logic          e, iv, m;
    logic [W1-1:0] id;
    for (int k = 0; k < 40; k++) begin
      case (k)
        0:       begin e = 1'b1; iv = 1'b1; id = 4'h7; m = 1'b0; end
        1:       begin e = 1'b0; iv = 1'b1; id = 4'h3; m = 1'b0; end
        2:       begin e = 1'b1; iv = 1'b0; id = 4'h9; m = 1'b0; end
        3:       begin e = 1'b1; iv = 1'b1; id = 4'hC; m = 1'b1; end
        default: begin
          e  = $urandom_range(0, 1) == 1;
          iv = $urandom_range(0, 1) == 1;
          id = W1'($urandom());
          m  = $urandom_range(0, 4) == 0;
        end
      endcase
      en1 = e; in_valid1 = iv; in_data1 = id; flush_mask1 = m;
      @(posedge clk);
      if (m)      begin v1 = 1'b0; d1 = RV1; end
      else if (e) begin v1 = iv;   d1 = iv ? id : RV1; end
      #1;
      n_cmp++;
      if ({out_valid1, out_data1, occupancy1} !== {v1, d1, v1}) begin
        n_err++;
        $display("FAIL depth1[%0d]: got v=%0b d=%0h occ=%0d want v=%0b d=%0h occ=%0d",
                 k, out_valid1, out_data1, occupancy1, v1, d1, v1);
      end
    end
    en1 = 1'b0; flush_mask1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0; in_valid = 1'b0; in_data = '0; flush_mask = '0;
    en1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; flush_mask1 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    test_reset();
    test_streaming();
    test_stall();
    test_squash_stall();
    test_squash_advance();
    test_full_flush();
    test_random();
    test_depth1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
